// File: rtl/parking_slot_manager_pkg.sv
// Shared constants, gate state encoding and occupancy helpers for the parking slot manager.
package parking_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int CAP_W     = 3;
  localparam int TIME_W    = 6;
  localparam logic [TIME_W-1:0] MAX_MS = TIME_W'(59);

  typedef enum logic {
    CLOSED = 1'b0,
    OPEN   = 1'b1
  } gate_state_e;

  function automatic logic [CAP_W-1:0] free_count(input logic [NUM_SLOTS-1:0] occ);
    free_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!occ[i]) free_count = free_count + CAP_W'(1);
    end
  endfunction

  // Scans from the top so the lowest free index is the last one written; 0 when full.
  function automatic logic [SLOT_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] occ);
    lowest_free = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occ[i]) lowest_free = SLOT_W'(i);
    end
  endfunction

endpackage

// File: rtl/parking_slot_manager_slot_timer.sv
// Per-slot mm:ss parked-time counter; advances on tick while run is high, saturates at 59:59.
module slot_timer
  import parking_pkg::*;
(
  input  logic              clk_500Hz,
  input  logic              reset,
  input  logic              clear,
  input  logic              run,
  input  logic              tick,
  output logic [TIME_W-1:0] minutes,
  output logic [TIME_W-1:0] seconds
);

  logic [TIME_W-1:0] min_q, min_d;
  logic [TIME_W-1:0] sec_q, sec_d;

  // A clear always beats a coincident tick so a newly claimed or vacated slot reads 00:00.
  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (clear) begin
      min_d = '0;
      sec_d = '0;
    end else if (run && tick) begin
      if (sec_q != MAX_MS) begin
        sec_d = sec_q + TIME_W'(1);
      end else if (min_q != MAX_MS) begin
        sec_d = '0;
        min_d = min_q + TIME_W'(1);
      end
    end
  end

  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      min_q <= '0;
      sec_q <= '0;
    end else begin
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;

endmodule

// File: rtl/parking_slot_manager.sv
// Four-slot car park controller: button edge detect, 1 s prescaler, gate FSM, occupancy
// tracking and per-slot parked-time counters feeding the multiplexed display.
module parking_slot_manager
  import parking_pkg::*;
#(
  parameter int TICK_DIV     = 500,
  parameter int GATE_SECONDS = 3
) (
  input  logic              clk_500Hz,
  input  logic              reset,
  input  logic              enter_btn,
  input  logic              exit_btn,
  input  logic [SLOT_W-1:0] exit_slot,
  input  logic [SLOT_W-1:0] view_slot,
  output logic [CAP_W-1:0]  capacity,
  output logic [SLOT_W-1:0] empty_slot,
  output logic              full,
  output logic [TIME_W-1:0] minutes,
  output logic [TIME_W-1:0] seconds,
  output logic              gate_open,
  output logic              reject
);

  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GCW = 4;

  logic                 enter_q, exit_q;
  logic [PW-1:0]        presc_q, presc_d;
  gate_state_e          gate_q, gate_d;
  logic [GCW-1:0]       gcnt_q, gcnt_d;
  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [NUM_SLOTS-1:0] clear_vec;
  logic [CAP_W-1:0]     capacity_q;
  logic [SLOT_W-1:0]    empty_slot_q;
  logic                 full_q, gate_open_q, reject_q, reject_d;
  logic [TIME_W-1:0]    minutes_q, seconds_q;

  logic                 tick, enter_ev, exit_ev, gate_closed, enter_acc, exit_acc;
  logic [SLOT_W-1:0]    free_idx;
  logic [TIME_W-1:0]    tmin [NUM_SLOTS];
  logic [TIME_W-1:0]    tsec [NUM_SLOTS];

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  assign enter_ev    = enter_btn & ~enter_q;
  assign exit_ev     = exit_btn & ~exit_q;
  assign gate_closed = (gate_q == CLOSED);
  assign free_idx    = lowest_free(occ_q);

  // An exit edge takes priority; any enter edge in the same cycle is refused.
  assign exit_acc  = exit_ev & gate_closed & occ_q[exit_slot];
  assign enter_acc = enter_ev & ~exit_ev & gate_closed & (occ_q != '1);
  assign reject_d  = (enter_ev & ~enter_acc) | (exit_ev & ~exit_acc);

  always_comb begin
    occ_d     = occ_q;
    clear_vec = '0;
    if (exit_acc) begin
      occ_d[exit_slot]     = 1'b0;
      clear_vec[exit_slot] = 1'b1;
    end
    if (enter_acc) begin
      occ_d[free_idx]     = 1'b1;
      clear_vec[free_idx] = 1'b1;
    end
  end

  always_comb begin
    gate_d = gate_q;
    gcnt_d = gcnt_q;
    case (gate_q)
      CLOSED: begin
        if (enter_acc || exit_acc) begin
          gate_d = OPEN;
          gcnt_d = GCW'(GATE_SECONDS);
        end
      end
      OPEN: begin
        if (tick) begin
          gcnt_d = gcnt_q - GCW'(1);
          if (gcnt_q == GCW'(1)) gate_d = CLOSED;
        end
      end
      default: gate_d = CLOSED;
    endcase
  end

  // Edge registers load the live button levels in reset so a held button is not a request.
  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      enter_q      <= enter_btn;
      exit_q       <= exit_btn;
      presc_q      <= '0;
      gate_q       <= CLOSED;
      gcnt_q       <= '0;
      occ_q        <= '0;
      capacity_q   <= CAP_W'(NUM_SLOTS);
      empty_slot_q <= '0;
      full_q       <= 1'b0;
      gate_open_q  <= 1'b0;
      reject_q     <= 1'b0;
      minutes_q    <= '0;
      seconds_q    <= '0;
    end else begin
      enter_q      <= enter_btn;
      exit_q       <= exit_btn;
      presc_q      <= presc_d;
      gate_q       <= gate_d;
      gcnt_q       <= gcnt_d;
      occ_q        <= occ_d;
      capacity_q   <= free_count(occ_d);
      empty_slot_q <= lowest_free(occ_d);
      full_q       <= (occ_d == '1);
      gate_open_q  <= (gate_d == OPEN);
      reject_q     <= reject_d;
      minutes_q    <= tmin[view_slot];
      seconds_q    <= tsec[view_slot];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_timer
      slot_timer u_timer (
        .clk_500Hz (clk_500Hz),
        .reset     (reset),
        .clear     (clear_vec[gi]),
        .run       (occ_q[gi]),
        .tick      (tick),
        .minutes   (tmin[gi]),
        .seconds   (tsec[gi])
      );
    end
  endgenerate

  assign capacity   = capacity_q;
  assign empty_slot = empty_slot_q;
  assign full       = full_q;
  assign minutes    = minutes_q;
  assign seconds    = seconds_q;
  assign gate_open  = gate_open_q;
  assign reject     = reject_q;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Self-checking bench: explicit vector table, hand-written corner sequences and random
// stimulus, all outputs compared every cycle against a seconds-based reference model.
module tb_parking_slot_manager;

  localparam int TICK_DIV     = 2;
  localparam int GATE_SECONDS = 1;
  localparam int MAX_TIME     = 59 * 60 + 59;

  logic       clk_500Hz = 1'b0;
  logic       reset = 1'b1;
  logic       enter_btn = 1'b0;
  logic       exit_btn = 1'b0;
  logic [1:0] exit_slot = 2'd0;
  logic [1:0] view_slot = 2'd0;
  logic [2:0] capacity;
  logic [1:0] empty_slot;
  logic       full;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       gate_open;
  logic       reject;

  parking_slot_manager #(.TICK_DIV(TICK_DIV), .GATE_SECONDS(GATE_SECONDS)) dut (
    .clk_500Hz  (clk_500Hz),
    .reset      (reset),
    .enter_btn  (enter_btn),
    .exit_btn   (exit_btn),
    .exit_slot  (exit_slot),
    .view_slot  (view_slot),
    .capacity   (capacity),
    .empty_slot (empty_slot),
    .full       (full),
    .minutes    (minutes),
    .seconds    (seconds),
    .gate_open  (gate_open),
    .reject     (reject)
  );

  always #5 clk_500Hz = ~clk_500Hz;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: occupancy flags, parked time in whole seconds, gate seconds remaining.
  bit m_occ [4];
  int m_time [4];
  int m_gate_rem = 0;
  int m_presc = 0;
  bit m_prev_en = 1'b0;
  bit m_prev_ex = 1'b0;
  bit m_rej = 1'b0;
  int m_view = 0;

  typedef struct {
    bit       en;
    bit       ex;
    bit [1:0] xslot;
    int       cap;
    int       empty;
    bit       full;
    bit       rej;
    bit       gate;
  } vec_t;

  vec_t vecs [11];

  task automatic model_update();
    bit en_ev, ex_ev, tick, closed, ent_ok, ex_ok;
    int nocc, free_slot;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_occ[i]  = 1'b0;
        m_time[i] = 0;
      end
      m_gate_rem = 0;
      m_presc    = 0;
      m_rej      = 1'b0;
      m_view     = 0;
    end else begin
      en_ev  = enter_btn && !m_prev_en;
      ex_ev  = exit_btn && !m_prev_ex;
      tick   = (m_presc == TICK_DIV - 1);
      closed = (m_gate_rem == 0);
      m_view = m_time[view_slot];
      nocc = 0;
      free_slot = -1;
      for (int i = 0; i < 4; i++) begin
        if (m_occ[i]) nocc++;
        else if (free_slot < 0) free_slot = i;
      end
      ex_ok  = ex_ev && closed && m_occ[exit_slot];
      ent_ok = en_ev && !ex_ev && closed && (nocc < 4);
      m_rej  = (en_ev && !ent_ok) || (ex_ev && !ex_ok);
      if (tick) begin
        for (int i = 0; i < 4; i++) begin
          if (m_occ[i] && m_time[i] < MAX_TIME) m_time[i]++;
        end
      end
      if (ex_ok) begin
        m_occ[exit_slot]  = 1'b0;
        m_time[exit_slot] = 0;
      end
      if (ent_ok) begin
        m_occ[free_slot]  = 1'b1;
        m_time[free_slot] = 0;
      end
      if (closed && (ex_ok || ent_ok)) m_gate_rem = GATE_SECONDS;
      else if (!closed && tick) m_gate_rem--;
      m_presc = (m_presc + 1) % TICK_DIV;
    end
    m_prev_en = enter_btn;
    m_prev_ex = exit_btn;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
  endtask

  task automatic check_all();
    int e_cap, e_empty;
    e_cap = 0;
    e_empty = -1;
    for (int i = 0; i < 4; i++) begin
      if (!m_occ[i]) begin
        e_cap++;
        if (e_empty < 0) e_empty = i;
      end
    end
    if (e_empty < 0) e_empty = 0;
    chk("model_capacity", capacity, e_cap);
    chk("model_empty_slot", empty_slot, e_empty);
    chk("model_full", full, (e_cap == 0) ? 1 : 0);
    chk("model_gate_open", gate_open, (m_gate_rem > 0) ? 1 : 0);
    chk("model_reject", reject, m_rej);
    chk("model_minutes", minutes, m_view / 60);
    chk("model_seconds", seconds, m_view % 60);
  endtask

  task automatic step();
    @(posedge clk_500Hz);
    model_update();
    #1;
    check_all();
    cyc++;
  endtask

  task automatic wait_gate_closed();
    int n = 0;
    while (gate_open && n < 10) begin
      step();
      n++;
    end
    chk("gate_close_bound", gate_open, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_capacity"}, capacity, 4);
    chk({tag, "_empty_slot"}, empty_slot, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_gate_open"}, gate_open, 0);
    chk({tag, "_reject"}, reject, 0);
    chk({tag, "_minutes"}, minutes, 0);
    chk({tag, "_seconds"}, seconds, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks, n, en_ev, ex_ev;

    //          en ex slot cap empty full rej gate
    vecs[0]  = '{1, 0, 0, 3, 1, 0, 0, 1};
    vecs[1]  = '{1, 0, 0, 2, 2, 0, 0, 1};
    vecs[2]  = '{1, 0, 0, 1, 3, 0, 0, 1};
    vecs[3]  = '{1, 0, 0, 0, 0, 1, 0, 1};
    vecs[4]  = '{1, 0, 0, 0, 0, 1, 1, 0};
    vecs[5]  = '{0, 1, 1, 1, 1, 0, 0, 1};
    vecs[6]  = '{0, 1, 1, 1, 1, 0, 1, 0};
    vecs[7]  = '{1, 0, 0, 0, 0, 1, 0, 1};
    vecs[8]  = '{0, 1, 3, 1, 3, 0, 0, 1};
    vecs[9]  = '{1, 1, 2, 2, 2, 0, 1, 1};
    vecs[10] = '{0, 1, 0, 3, 0, 0, 0, 1};

    // Button held through reset must not register as a request.
    enter_btn = 1'b1;
    do_reset();
    #1;
    check_reset_values("reset");
    step();
    step();
    chk("held_btn_capacity", capacity, 4);
    chk("held_btn_reject", reject, 0);
    enter_btn = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      enter_btn = vecs[i].en;
      exit_btn  = vecs[i].ex;
      exit_slot = vecs[i].xslot;
      step();
      $display("vec %0d en=%0b ex=%0b slot=%0d -> cap=%0d empty=%0d full=%0b rej=%0b gate=%0b",
               i, vecs[i].en, vecs[i].ex, vecs[i].xslot, capacity, empty_slot, full, reject, gate_open);
      chk($sformatf("vec%0d_capacity", i), capacity, vecs[i].cap);
      chk($sformatf("vec%0d_empty_slot", i), empty_slot, vecs[i].empty);
      chk($sformatf("vec%0d_full", i), full, vecs[i].full);
      chk($sformatf("vec%0d_reject", i), reject, vecs[i].rej);
      chk($sformatf("vec%0d_gate_open", i), gate_open, vecs[i].gate);
      enter_btn = 1'b0;
      exit_btn  = 1'b0;
      step();
      wait_gate_closed();
    end

    // Vacated slots must read 00:00.
    for (int s = 2; s < 4; s++) begin
      view_slot = 2'(s);
      step();
      step();
      $display("view freed slot %0d -> %0d:%0d", s, minutes, seconds);
      chk($sformatf("freed%0d_minutes", s), minutes, 0);
      chk($sformatf("freed%0d_seconds", s), seconds, 0);
    end

    // Second entry while the gate is still open; first accepted on a tick edge.
    n = 0;
    while (m_presc != TICK_DIV - 1 && n < 4) begin
      step();
      n++;
    end
    enter_btn = 1'b1;
    step();
    $display("double entry #1 -> cap=%0d gate=%0b rej=%0b", capacity, gate_open, reject);
    chk("dbl1_capacity", capacity, 2);
    chk("dbl1_gate_open", gate_open, 1);
    chk("dbl1_reject", reject, 0);
    enter_btn = 1'b0;
    step();
    chk("dbl_hold_gate_open", gate_open, 1);
    enter_btn = 1'b1;
    step();
    $display("double entry #2 -> cap=%0d gate=%0b rej=%0b", capacity, gate_open, reject);
    chk("dbl2_capacity", capacity, 2);
    chk("dbl2_gate_open", gate_open, 0);
    chk("dbl2_reject", reject, 1);
    enter_btn = 1'b0;
    step();

    // Slot 0 parked-time: 1:05 after 65 ticks, then saturation at 59:59.
    view_slot = 2'd0;
    do_reset();
    step();
    enter_btn = 1'b1;
    step();
    enter_btn = 1'b0;
    ticks = 0;
    while (ticks < 65) begin
      if (m_presc == TICK_DIV - 1) ticks++;
      step();
    end
    step();
    $display("timer after 65 ticks -> %0d:%0d", minutes, seconds);
    chk("t65_minutes", minutes, 1);
    chk("t65_seconds", seconds, 5);
    while (ticks < MAX_TIME) begin
      if (m_presc == TICK_DIV - 1) ticks++;
      step();
    end
    step();
    $display("timer after %0d ticks -> %0d:%0d", ticks, minutes, seconds);
    chk("tmax_minutes", minutes, 59);
    chk("tmax_seconds", seconds, 59);
    while (ticks < MAX_TIME + 10) begin
      if (m_presc == TICK_DIV - 1) ticks++;
      step();
    end
    step();
    $display("timer after %0d ticks -> %0d:%0d", ticks, minutes, seconds);
    chk("tsat_minutes", minutes, 59);
    chk("tsat_seconds", seconds, 59);

    // Reset asserted while the gate is open.
    enter_btn = 1'b1;
    step();
    chk("rstgate_gate_open", gate_open, 1);
    chk("rstgate_capacity", capacity, 2);
    enter_btn = 1'b0;
    reset = 1'b1;
    step();
    $display("reset mid-gate -> cap=%0d gate=%0b", capacity, gate_open);
    check_reset_values("rstgate");
    reset = 1'b0;
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      enter_btn = ($urandom_range(0, 4) == 0);
      exit_btn  = ($urandom_range(0, 4) == 0);
      exit_slot = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) view_slot = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) == 0);
      en_ev = (enter_btn && !m_prev_en) ? 1 : 0;
      ex_ev = (exit_btn && !m_prev_ex) ? 1 : 0;
      step();
      if ((en_ev != 0 || ex_ev != 0) && !reset)
        $display("rand cyc=%0d en=%0d ex=%0d slot=%0d -> cap=%0d empty=%0d rej=%0b gate=%0b",
                 cyc, en_ev, ex_ev, exit_slot, capacity, empty_slot, reject, gate_open);
    end
    reset = 1'b0;
    enter_btn = 1'b0;
    exit_btn = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
